// File: rtl/serial_frame_rx.sv
// serial_frame_rx: serial-to-parallel frame receiver with a one-entry output buffer.
// Samples s on bit strobes (en), detects the start bit (~STOP_LEVEL), assembles W data
// bits LSB-first, checks the stop bit and hands the word out through a valid/ready buffer.
// Optional feature macro: PARITY_CHECK_EN adds one even-parity bit after the data bits;
// a parity mismatch is reported like a bad stop bit.
// Ports:
//   c     in   clock, rising edge
//   rst   in   synchronous active-high reset
//   s     in   serial line, idle level = STOP_LEVEL
//   en    in   bit strobe, s sampled only when en=1
//   rdy   in   consumer ready, transfer when v & rdy
//   q     out  [W-1:0] buffered data word
//   v     out  buffer holds an unread word
//   ferr  out  sticky framing (or parity) error
//   ovr   out  sticky overrun
//   busy  out  FSM not idle
module serial_frame_rx #(
  parameter int unsigned W          = 8,
  parameter logic        STOP_LEVEL = 1'b1
) (
  input  logic         c,
  input  logic         rst,
  input  logic         s,
  input  logic         en,
  input  logic         rdy,
  output logic [W-1:0] q,
  output logic         v,
  output logic         ferr,
  output logic         ovr,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_sh;
  logic [W-1:0]   r_q;
  logic           r_v;
  logic           r_ferr;
  logic           r_ovr;
  logic           r_busy;

  logic           w_start;
  logic           w_shift;
  logic           w_stop;
  logic           w_frame_ok;
  logic           w_good;
  logic           w_bad;
  logic           w_read;
  logic [W-1:0]   w_sh_nxt;

`ifdef PARITY_CHECK_EN
  logic           r_par;
  logic           r_pbit;
  logic           w_pcap;
`endif

  // State register
  always_ff @(posedge c) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; every transition requires a strobe
  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        S_IDLE: if (s == ~STOP_LEVEL) w_state_nxt = S_DATA;
        S_DATA: begin
          if (r_cnt == CW'(W - 1)) begin
`ifdef PARITY_CHECK_EN
            w_state_nxt = S_PAR;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        S_PAR:  w_state_nxt = S_STOP;
`else
        S_PAR:  w_state_nxt = S_IDLE;
`endif
        S_STOP: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Decoded per-edge actions
  always_comb begin
    w_start  = en && (r_state == S_IDLE) && (s == ~STOP_LEVEL);
    w_shift  = en && (r_state == S_DATA);
    w_stop   = en && (r_state == S_STOP);
    // New bit enters at the MSB so the first data bit ends in bit 0
    w_sh_nxt = (r_sh >> 1) | (W'(s) << (W - 1));
`ifdef PARITY_CHECK_EN
    w_pcap     = en && (r_state == S_PAR);
    w_frame_ok = (s == STOP_LEVEL) && (r_par == r_pbit);
`else
    w_frame_ok = (s == STOP_LEVEL);
`endif
    w_good   = w_stop && w_frame_ok;
    w_bad    = w_stop && !w_frame_ok;
    w_read   = r_v && rdy;
  end

  // Datapath, output buffer and sticky flags
  always_ff @(posedge c) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sh   <= '0;
      r_q    <= '0;
      r_v    <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      r_busy <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par  <= 1'b0;
      r_pbit <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_start) begin
        r_cnt <= '0;
`ifdef PARITY_CHECK_EN
        r_par <= 1'b0;
`endif
      end
      if (w_shift) begin
        r_sh  <= w_sh_nxt;
        r_cnt <= r_cnt + CW'(1);
`ifdef PARITY_CHECK_EN
        r_par <= r_par ^ s;
`endif
      end
`ifdef PARITY_CHECK_EN
      if (w_pcap) r_pbit <= s;
`endif
      // A commit into a buffer that is being read in the same edge keeps v high
      if (w_good) begin
        if (!r_v || rdy) begin
          r_q <= r_sh;
          r_v <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_read) begin
        r_v <= 1'b0;
      end
      if (w_bad) r_ferr <= 1'b1;
    end
  end

  assign q    = r_q;
  assign v    = r_v;
  assign ferr = r_ferr;
  assign ovr  = r_ovr;
  assign busy = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (W=8, STOP_LEVEL=1).
module tb_serial_frame_rx;

  logic       c;
  logic       rst;
  logic       s;
  logic       en;
  logic       rdy;
  logic [7:0] q;
  logic       v;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int total;
  int bad;

  serial_frame_rx #(.W(8), .STOP_LEVEL(1'b1)) dut (
    .c(c), .rst(rst), .s(s), .en(en), .rdy(rdy),
    .q(q), .v(v), .ferr(ferr), .ovr(ovr), .busy(busy)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // One strobed bit after gap non-strobe cycles; returns 1 time unit after the strobe edge
  task automatic strobe(input logic b, input int gap, input logic r);
    for (int i = 0; i < gap; i++) begin
      @(negedge c);
      en = 1'b0; rdy = 1'b0; s = 1'b1;
    end
    @(negedge c);
    s = b; en = 1'b1; rdy = r;
    @(posedge c);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge c);
    en = 1'b0; rdy = 1'b0; s = 1'b1;
    @(posedge c);
    #1;
  endtask

  task automatic read_cycle();
    @(negedge c);
    en = 1'b0; rdy = 1'b1; s = 1'b1;
    @(posedge c);
    #1;
    @(negedge c);
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge c);
    rst = 1'b1; en = 1'b0; rdy = 1'b0; s = 1'b1;
    @(posedge c);
    #1;
    @(negedge c);
    rst = 1'b0;
  endtask

  // Full frame: start, 8 data bits LSB-first, [parity], stop. rdy_stop drives rdy on the stop strobe.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int gap,
                            input logic flip_par, input logic rdy_stop);
    strobe(1'b0, gap, 1'b0);
    for (int i = 0; i < 8; i++) strobe(d[i], gap, 1'b0);
`ifdef PARITY_CHECK_EN
    strobe((^d) ^ flip_par, gap, 1'b0);
`else
    if (flip_par) begin end
`endif
    strobe(stopb, gap, rdy_stop);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; rdy = 1'b0; s = 1'b1;
    @(posedge c);
    #1;
    total++; if (q !== 8'h00)  begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (v !== 1'b0)   begin bad++; $display("FAIL reset_v got=%b exp=0", v); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge c);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    // Idle line with strobes must never start a frame
    for (int i = 0; i < 5; i++) strobe(1'b1, 0, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    strobe(1'b0, 0, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) strobe(((8'h4A >> i) & 8'h01) != 0, 0, 1'b0);
`ifdef PARITY_CHECK_EN
    strobe(1'b1, 0, 1'b0);
`endif
    total++; if (v !== 1'b0) begin bad++; $display("FAIL pre_stop_v got=%b exp=0", v); end
    strobe(1'b1, 0, 1'b0);
    total++; if (q !== 8'h4A) begin bad++; $display("FAIL basic_q got=%h exp=4a", q); end
    total++; if (v !== 1'b1)  begin bad++; $display("FAIL basic_v got=%b exp=1", v); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
    read_cycle();
    total++; if (v !== 1'b0)  begin bad++; $display("FAIL basic_read_v got=%b exp=0", v); end
    total++; if (q !== 8'h4A) begin bad++; $display("FAIL basic_read_q got=%h exp=4a", q); end
  endtask

  task automatic test_ferr();
    send_frame(8'h4A, 1'b0, 0, 1'b0, 1'b0);
    total++; if (v !== 1'b0)    begin bad++; $display("FAIL ferr_v got=%b exp=0", v); end
    total++; if (ferr !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", ferr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0);
    total++; if (q !== 8'hFF) begin bad++; $display("FAIL after_ferr_q got=%h exp=ff", q); end
    total++; if (v !== 1'b1)  begin bad++; $display("FAIL after_ferr_v got=%b exp=1", v); end
    read_cycle();
    do_reset();
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", ferr); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", ovr); end
    send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
    total++; if (q !== 8'h11) begin bad++; $display("FAIL ovr_q got=%h exp=11", q); end
    total++; if (v !== 1'b1)  begin bad++; $display("FAIL ovr_v got=%b exp=1", v); end
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", ovr); end
    read_cycle();
    total++; if (v !== 1'b0) begin bad++; $display("FAIL ovr_read_v got=%b exp=0", v); end
    idle_cycle();
    total++; if (ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", ovr); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    // Second frame completes on the same edge the first word is read
    send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b1);
    total++; if (q !== 8'hC3) begin bad++; $display("FAIL b2b_q got=%h exp=c3", q); end
    total++; if (v !== 1'b1)  begin bad++; $display("FAIL b2b_v got=%b exp=1", v); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b exp=0", ovr); end
    read_cycle();
  endtask

  task automatic test_sparse_en();
    do_reset();
    send_frame(8'hA5, 1'b1, 2, 1'b0, 1'b0);
    total++; if (q !== 8'hA5) begin bad++; $display("FAIL sparse_q got=%h exp=a5", q); end
    total++; if (v !== 1'b1)  begin bad++; $display("FAIL sparse_v got=%b exp=1", v); end
    read_cycle();
    strobe(1'b0, 2, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b0, 2, 1'b0);
    // No strobe for a few cycles: state must hold
    idle_cycle(); idle_cycle();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midframe_busy got=%b exp=1", busy); end
    do_reset();
    total++; if (v !== 1'b0)    begin bad++; $display("FAIL midrst_v got=%b exp=0", v); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL midrst_ferr got=%b exp=0", ferr); end
    total++; if (q !== 8'h00)   begin bad++; $display("FAIL midrst_q got=%h exp=00", q); end
    send_frame(8'h81, 1'b1, 0, 1'b0, 1'b0);
    total++; if (q !== 8'h81) begin bad++; $display("FAIL post_rst_q got=%h exp=81", q); end
    read_cycle();
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    do_reset();
    send_frame(8'h03, 1'b1, 0, 1'b0, 1'b0);
    total++; if (q !== 8'h03) begin bad++; $display("FAIL par_ok_q got=%h exp=03", q); end
    total++; if (v !== 1'b1)  begin bad++; $display("FAIL par_ok_v got=%b exp=1", v); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL par_ok_ferr got=%b exp=0", ferr); end
    read_cycle();
    send_frame(8'h03, 1'b1, 0, 1'b1, 1'b0);
    total++; if (ferr !== 1'b1) begin bad++; $display("FAIL par_bad_ferr got=%b exp=1", ferr); end
    total++; if (v !== 1'b0)    begin bad++; $display("FAIL par_bad_v got=%b exp=0", v); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; rdy = 1'b0; s = 1'b1;
    test_reset();
    test_basic();
    test_ferr();
    test_overrun();
    test_back_to_back();
    test_sparse_en();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
